// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the iterative signed divider.
// Build option: SEQ_DIV_SAT_EN (saturating quotient narrowing; default wraps).
package seq_div_pkg;

  // Operand width; dividend is twice as wide.
  localparam int BITWIDTH = 16;
  localparam int DIV_W    = 2 * BITWIDTH;

  // Counter counts 0..DIV_W-1.
  localparam int CNT_W = $clog2(DIV_W + 1);

  // Signed BITWIDTH range limits as raw bit patterns.
  localparam logic [BITWIDTH-1:0] QMAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] QMIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: request/result handshake bundle of the divider.
interface seq_div_if;
  import seq_div_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DIV_W-1:0]    dividend;
  logic [BITWIDTH-1:0] divisor;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] quotient;
  logic [BITWIDTH-1:0] remainder;
  logic                ovf;
  logic                dbz;

  // Requester / result consumer side.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring radix-2 iteration on unsigned magnitudes.
module seq_div_step
  import seq_div_pkg::*;
(
  input  logic [BITWIDTH-1:0] rem_in,
  input  logic                dvd_bit,
  input  logic [BITWIDTH-1:0] dvs_mag,
  output logic [BITWIDTH-1:0] rem_out,
  output logic                q_bit
);

  logic [BITWIDTH:0]   trial;
  logic [BITWIDTH-1:0] diff;

  // Shift in the next dividend bit, subtract when it fits, else restore.
  // rem_in < dvs_mag, so the kept remainder always fits BITWIDTH bits and the
  // low-BITWIDTH subtraction is exact whenever the subtraction is taken.
  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial[BITWIDTH-1:0] - dvs_mag;
    q_bit   = (trial >= {1'b0, dvs_mag});
    rem_out = q_bit ? diff : trial[BITWIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative signed divider, 2*BITWIDTH-bit dividend by BITWIDTH-bit
// divisor, one quotient bit per clock, valid/ready on both sides.
// Build option: SEQ_DIV_SAT_EN saturates an out-of-range quotient; otherwise
// the quotient wraps to its low BITWIDTH bits. ovf flags it either way.
module seq_div
  import seq_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  seq_div_if.slave   bus
);

  // Largest quotient magnitudes that still fit, positive and negative.
  localparam logic [DIV_W-1:0] MAG_POS = {{BITWIDTH{1'b0}}, QMAX};
  localparam logic [DIV_W-1:0] MAG_NEG = {{BITWIDTH{1'b0}}, QMIN};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DIV_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    acc_q, acc_d;        // dividend magnitude, then quotient
  logic [BITWIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [BITWIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic                neg_q_q, neg_q_d;    // quotient is negative
  logic                neg_r_q, neg_r_d;    // dividend (and remainder) negative
  logic [BITWIDTH-1:0] quo_q, quo_d;
  logic [BITWIDTH-1:0] rmd_q, rmd_d;
  logic                ovf_q, ovf_d;
  logic                dbz_q, dbz_d;
  logic                out_valid_q, out_valid_d;

  logic [BITWIDTH-1:0] step_rem;
  logic                step_q_bit;
  logic                q_ovf;
  logic [BITWIDTH-1:0] q_wrap;

  seq_div_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (acc_q[DIV_W-1]),
    .dvs_mag (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Sign fix-up of the finished magnitude quotient; the low bits of the
  // negated full quotient equal the negation of its low bits.
  always_comb begin
    q_ovf  = neg_q_q ? (acc_q > MAG_NEG) : (acc_q > MAG_POS);
    q_wrap = neg_q_q ? (~acc_q[BITWIDTH-1:0] + 1'b1) : acc_q[BITWIDTH-1:0];
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          neg_r_d = bus.dividend[DIV_W-1];
          neg_q_d = bus.dividend[DIV_W-1] ^ bus.divisor[BITWIDTH-1];
          acc_d   = bus.dividend[DIV_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
          dvs_d   = bus.divisor[BITWIDTH-1] ? (~bus.divisor + 1'b1) : bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          if (bus.divisor == '0) begin
            quo_d       = bus.dividend[DIV_W-1] ? QMIN : QMAX;
            rmd_d       = '0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = {acc_q[DIV_W-2:0], step_q_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) state_d = FIN;
      end
      FIN: begin
`ifdef SEQ_DIV_SAT_EN
        quo_d = q_ovf ? (neg_q_q ? QMIN : QMAX) : q_wrap;
`else
        quo_d = q_wrap;
`endif
        rmd_d       = neg_r_q ? (~rem_q + 1'b1) : rem_q;
        ovf_d       = q_ovf;
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vectors for seq_div (BITWIDTH=16), hand-computed results.
module tb_seq_div;
  import seq_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seq_div_if bus();

  seq_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SEQ_DIV_SAT_EN
  localparam logic [15:0] Q_BIG = 16'h7FFF;
`else
  localparam logic [15:0] Q_BIG = 16'h0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; return just after the accept edge.
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    @(negedge clk);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(input string tag, input int lat_exp);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat_exp);
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic o, input logic z);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_quot"},  {16'd0, bus.quotient}, {16'd0, q});
    check({tag, "_rem"},   {16'd0, bus.remainder}, {16'd0, r});
    check({tag, "_ovf"},   {31'd0, bus.ovf}, {31'd0, o});
    check({tag, "_dbz"},   {31'd0, bus.dbz}, {31'd0, z});
    $display("op %-10s q=%04h r=%04h ovf=%0d dbz=%0d", tag, bus.quotient, bus.remainder,
             bus.ovf, bus.dbz);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                        input int lat, input logic [15:0] q, input logic [15:0] r,
                        input logic o, input logic z);
    start_op(dvd, dvs);
    wait_result(tag, lat);
    check_result(tag, q, r, o, z);
    consume(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_quot",      {16'd0, bus.quotient}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Signed quadrants: 1000/7 = 142 r 6.
    run_op("p_p",   32'd1000,       16'd7,      33, 16'd142,   16'd6,    1'b0, 1'b0);
    run_op("n_p",   -32'sd1000,     16'd7,      33, 16'hFF72,  16'hFFFA, 1'b0, 1'b0);
    run_op("p_n",   32'd1000,       16'hFFF9,   33, 16'hFF72,  16'd6,    1'b0, 1'b0);
    run_op("n_n",   -32'sd1000,     16'hFFF9,   33, 16'd142,   16'hFFFA, 1'b0, 1'b0);
    // Range edges: -32768 fits, +32768 does not.
    run_op("qmin",  32'hFFFF_8000,  16'd1,      33, 16'h8000,  16'd0,    1'b0, 1'b0);
    run_op("ovf2",  32'h4000_0000,  16'd2,      33, Q_BIG,     16'd0,    1'b1, 1'b0);
    run_op("ovfm1", 32'h8000_0000,  16'hFFFF,   33, Q_BIG,     16'd0,    1'b1, 1'b0);
    // Divide by zero: result in the cycle right after the accept edge.
    run_op("dbz_p", 32'd5,          16'd0,      0,  16'h7FFF,  16'd0,    1'b0, 1'b1);
    run_op("dbz_n", -32'sd5,        16'd0,      0,  16'h8000,  16'd0,    1'b0, 1'b1);

    // Backpressure: hold result for 10 cycles with a competing request.
    start_op(32'd1000, 16'd7);
    wait_result("bp", 33);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 16'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_quot",  {16'd0, bus.quotient}, 32'd142);
      check("bp_hold_rem",   {16'd0, bus.remainder}, 32'd6);
      check("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    check_result("bp", 16'd142, 16'd6, 1'b0, 1'b0);
    consume("bp");

    // Reset during CALC iteration 10.
    start_op(32'd1000, 16'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_quot",  {16'd0, bus.quotient}, 32'd0);
    check("mid_rst_rem",   {16'd0, bus.remainder}, 32'd0);
    check("mid_rst_ovf",   {31'd0, bus.ovf}, 32'd0);
    check("mid_rst_dbz",   {31'd0, bus.dbz}, 32'd0);
    run_op("after_rst", 32'd1000, 16'd7, 33, 16'd142, 16'd6, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
